serial_mag_compare_ctrl: RTL

//  Sequencer that compares two WIDTH-bit operands by walking them MSB-first, one 2-bit digit per cycle,

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp2_slice.sv | 18 +
 rtl/serial_mag_compare_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_e : controller state, 2-bit encoding {IDLE, SCAN, DONE}
//   RES_*   : one-hot result vectors laid out as {gt, eq, lt}
//   res_pack: packs the three slice flags into that layout
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b100;

  function automatic logic [2:0] res_pack(input logic lt, input logic eq, input logic gt);
    return {gt, eq, lt};
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit magnitude compare.
//   i_a, i_b : 2-bit digits
//   o_lt     : i_a <  i_b
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b
module cmp2_slice (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_lt,
  output logic       o_eq,
  output logic       o_gt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB-first, one 2-bit digit per
// cycle, through a single shared cmp2_slice, stopping at the first unequal digit.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand handshake, in_a/in_b sampled on accept only
//   flush                : synchronous abort, wins over accept and result handshake
//   out_valid/out_ready  : result handshake
//   a_less_b/a_equal_b/a_greater_b : one-hot result, all zero outside DONE
//   scan_cycles          : SCAN cycles spent on the current result
//   busy                 : controller not in IDLE
// Build option: define SIGNED_CMP_EN for two's complement operands (sign bit of the top digit
// inverted before the slice); leave undefined for an unsigned compare.
module serial_mag_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH / 2) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_less_b,
  output logic             a_equal_b,
  output logic             a_greater_b,
  output logic [CNT_W-1:0] scan_cycles,
  output logic             busy
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_res;

  logic [1:0] w_dig_a;
  logic [1:0] w_dig_b;
  logic [1:0] w_slice_a;
  logic [1:0] w_slice_b;
  logic       w_lt;
  logic       w_eq;
  logic       w_gt;
  logic       w_accept;
  logic       w_scan_end;
  logic       w_release;

  // Digit mux feeding the single shared slice.
  always_comb begin
    w_dig_a = 2'b00;
    w_dig_b = 2'b00;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_dig_a = r_a[2*i +: 2];
        w_dig_b = r_b[2*i +: 2];
      end
    end
  end

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    w_slice_a = w_dig_a;
    w_slice_b = w_dig_b;
    if (r_idx == IDX_TOP) begin
      w_slice_a[1] = ~w_dig_a[1];
      w_slice_b[1] = ~w_dig_b[1];
    end
  end
`else
  assign w_slice_a = w_dig_a;
  assign w_slice_b = w_dig_b;
`endif

  cmp2_slice u_slice (
    .i_a  (w_slice_a),
    .i_b  (w_slice_b),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  assign w_accept   = (r_state == IDLE) && in_valid && !flush;
  // Unequal digit decides; an equal last digit means the operands are equal.
  assign w_scan_end = (r_state == SCAN) && !flush && (!w_eq || (r_idx == '0));
  assign w_release  = (r_state == DONE) && (out_ready || flush);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (in_valid) w_state_next = SCAN;
        SCAN:    if (!w_eq || (r_idx == '0)) w_state_next = DONE;
        DONE:    if (out_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (r_state == IDLE) && !flush;
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Operand, index and scan counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_idx <= IDX_TOP;
      r_cnt <= '0;
    end else if (r_state == SCAN) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_scan_end) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  // Result register: non-zero only while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= RES_NONE;
    end else if (w_release || flush) begin
      r_res <= RES_NONE;
    end else if (w_scan_end) begin
      r_res <= res_pack(w_lt, w_eq, w_gt);
    end
  end

  assign a_less_b    = r_res[0];
  assign a_equal_b   = r_res[1];
  assign a_greater_b = r_res[2];
  assign scan_cycles = r_cnt;

endmodule
